// File: rtl/s2p_pkg.sv
// Shared constants and helpers for the serial-to-parallel stream assembler.
package s2p_pkg;

  localparam bit LSB_FIRST = 1'b0;
  localparam bit MSB_FIRST = 1'b1;

  // Width needed to hold a beat count in the range 0..n_beats inclusive.
  function automatic int beat_count_width(input int n_beats);
    return $clog2(n_beats + 1);
  endfunction

endpackage

// File: rtl/s2p_out_reg.sv
// One-entry valid/ready holding register for assembled parallel words.
module s2p_out_reg #(
  parameter int data_w = 8,
  parameter int cnt_w  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [data_w-1:0] load_data,
  input  logic [cnt_w-1:0]  load_beats,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [data_w-1:0] out_data,
  output logic [cnt_w-1:0]  out_beats,
  output logic              free
);

  // A new word may enter when the slot is empty or is being drained this cycle.
  assign free = !out_valid || out_ready;

  // Holding register: data and beat count stay put until the next load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_beats <= load_beats;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: rtl/serial_to_parallel_stream.sv
// Assembles serial beats into parallel words with valid/ready on both sides.
// Define S2P_PARTIAL_FLUSH_EN to emit partial words on flush instead of discarding them.
module serial_to_parallel_stream
  import s2p_pkg::*;
#(
  parameter int lane_width = 1,
  parameter int n_beats    = 8,
  parameter bit msb_first  = LSB_FIRST
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  serial_valid,
  output logic                                  serial_ready,
  input  logic [lane_width-1:0]                 serial_data,
  input  logic                                  flush,
  output logic                                  parallel_valid,
  input  logic                                  parallel_ready,
  output logic [lane_width*n_beats-1:0]         parallel_data,
  output logic [beat_count_width(n_beats)-1:0]  parallel_beats
);

  localparam int DATA_W = lane_width * n_beats;
  localparam int CNT_W  = beat_count_width(n_beats);

`ifdef S2P_PARTIAL_FLUSH_EN
  localparam bit PARTIAL_FLUSH = 1'b1;
`else
  localparam bit PARTIAL_FLUSH = 1'b0;
`endif

  logic [CNT_W-1:0]  count_r, count_next_s, lane_s, load_beats_s;
  logic [DATA_W-1:0] acc_r, acc_next_s, word_next_s, load_data_s;
  logic              free_s, last_s, accept_s, load_s;
  int                lane_base_s;

  assign last_s       = (count_r == CNT_W'(n_beats - 1));
  assign serial_ready = rst && !flush && (!last_s || free_s);
  assign accept_s     = serial_valid && serial_ready;

  // Place the incoming beat into its lane of a copy of the accumulator.
  always_comb begin
    lane_s = count_r;
    if (msb_first == MSB_FIRST) begin
      lane_s = CNT_W'(n_beats - 1) - count_r;
    end else begin
      lane_s = count_r;
    end
    lane_base_s = int'(lane_s) * lane_width;
    word_next_s = acc_r;
    word_next_s[lane_base_s +: lane_width] = serial_data;
  end

  // Next accumulator/count and output-register load decision.
  always_comb begin
    load_s       = 1'b0;
    load_data_s  = word_next_s;
    load_beats_s = CNT_W'(n_beats);
    acc_next_s   = acc_r;
    count_next_s = count_r;
    if (flush) begin
      if (PARTIAL_FLUSH && (count_r != '0)) begin
        // Partial word waits here until the output slot can take it.
        if (free_s) begin
          load_s       = 1'b1;
          load_data_s  = acc_r;
          load_beats_s = count_r;
          acc_next_s   = '0;
          count_next_s = '0;
        end else begin
          acc_next_s   = acc_r;
          count_next_s = count_r;
        end
      end else begin
        acc_next_s   = '0;
        count_next_s = '0;
      end
    end else if (accept_s) begin
      if (last_s) begin
        load_s       = 1'b1;
        acc_next_s   = '0;
        count_next_s = '0;
      end else begin
        acc_next_s   = word_next_s;
        count_next_s = count_r + CNT_W'(1);
      end
    end else begin
      acc_next_s   = acc_r;
      count_next_s = count_r;
    end
  end

  // Accumulator and beat counter state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= '0;
      acc_r   <= '0;
    end else begin
      count_r <= count_next_s;
      acc_r   <= acc_next_s;
    end
  end

  s2p_out_reg #(
    .data_w(DATA_W),
    .cnt_w (CNT_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_data (load_data_s),
    .load_beats(load_beats_s),
    .out_ready (parallel_ready),
    .out_valid (parallel_valid),
    .out_data  (parallel_data),
    .out_beats (parallel_beats),
    .free      (free_s)
  );

endmodule

// File: doc/serial_to_parallel_stream.md
SERIAL_TO_PARALLEL_STREAM -- requirements
Module: serial_to_parallel_stream

Interface
REQ-001 The block SHALL have parameter lane_width, default 1, meaning bits per serial beat.
REQ-002 The block SHALL have parameter n_beats, default 8, meaning beats per parallel word (n_beats >= 2).
REQ-003 The block SHALL have parameter msb_first, default 0, meaning 0 = first beat lands in the least-significant lane, 1 = first beat lands in the most-significant lane.
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-006 The block SHALL have port rst, input, 1, synchronous active-low reset.
REQ-007 The block SHALL have port serial_valid, input, 1, beat offered.
REQ-008 The block SHALL have port serial_ready, output, 1, beat accepted when serial_valid and serial_ready are both high.
REQ-009 The block SHALL have port serial_data, input, lane_width, beat payload.
REQ-010 The block SHALL have port flush, input, 1, terminates the current partial word.
REQ-011 The block SHALL have port parallel_valid, output, 1, word available.
REQ-012 The block SHALL have port parallel_ready, input, 1, word consumed when parallel_valid and parallel_ready are both high.
REQ-013 The block SHALL have port parallel_data, output, lane_width*n_beats, assembled word.
REQ-014 The block SHALL have port parallel_beats, output, $clog2(n_beats+1), number of valid beats in parallel_data.

Function
REQ-015 Accepted beats SHALL be written into an accumulator lane selected by a beat counter 0..n_beats-1: lane = count for msb_first = 0, lane = n_beats-1-count for msb_first = 1.
REQ-016 The output register SHALL be free when parallel_valid is low, or when parallel_valid and parallel_ready are both high in the same cycle.
REQ-017 serial_ready SHALL be high when flush is low AND either count < n_beats-1 or the output register is free.
REQ-018 Acceptance of the final beat (count = n_beats-1) SHALL load the output register with the complete word and parallel_beats = n_beats, assert parallel_valid on the next cycle (latency 1 cycle), clear the accumulator and wrap count to 0.
REQ-019 Back-to-back words SHALL sustain 1 beat per cycle while parallel_ready is held high.
REQ-020 parallel_valid, parallel_data and parallel_beats SHALL be held stable until the word is consumed; parallel_valid SHALL deassert on the cycle after consumption unless a new word is loaded in the same cycle.
REQ-021 When flush is high, count SHALL be cleared and the accumulator SHALL be cleared at the next edge; no beat is accepted in that cycle.
REQ-022 A flush with count = 0 SHALL have no effect other than blocking serial_ready.
REQ-023 Unfilled lanes of any word SHALL be zero.

Reset
REQ-024 While rst is low at a rising edge: count = 0, accumulator = 0, parallel_valid = 0, parallel_data = 0, parallel_beats = 0.
REQ-025 serial_ready SHALL be 0 while rst is low.
REQ-026 A reset mid-word SHALL discard the partial word with no output.
REQ-027 A reset while parallel_valid = 1 SHALL drop the pending word.

Configuration
REQ-028 Macro S2P_PARTIAL_FLUSH_EN SHALL select partial-word flush behaviour.
REQ-029 Without S2P_PARTIAL_FLUSH_EN, a flush SHALL discard the partial word, and parallel_beats SHALL always equal n_beats when valid.
REQ-030 With S2P_PARTIAL_FLUSH_EN, a flush with count > 0 SHALL be held (blocking serial_ready) until the output register is free, then load the partial word with parallel_beats = count and clear the accumulator.

Structure
REQ-031 Package s2p_pkg SHALL hold the lane-order constants LSB_FIRST = 0 and MSB_FIRST = 1, plus a function computing the beat-count width.
REQ-032 Sub-module s2p_out_reg SHALL implement the one-entry valid/ready output holding register, parametrised by data width and count width.

Verification
REQ-033 Reset plus nominal assembly: lane_width=1, n_beats=8, LSB-first, beats 1,0,1,1,0,0,1,0 with parallel_ready high -> parallel_data = 8'h4D one cycle after the last beat, parallel_beats = 8.
REQ-034 MSB-first multi-bit: lane_width=4, n_beats=4, msb_first=1, beats A,B,C,D -> parallel_data = 16'hABCD.
REQ-035 Backpressure: parallel_ready low with a word pending and 7 more beats accepted -> serial_ready drops at count=7; parallel_ready raised -> the final beat is accepted in the same cycle and the next word appears on the following cycle with no loss.
REQ-036 Flush without the macro: 3 beats then flush -> no output, count = 0, and the next 8 beats form a clean word.
REQ-037 Flush with S2P_PARTIAL_FLUSH_EN: 3 beats 1,1,1 then flush -> parallel_data = 8'h07, parallel_beats = 3.
REQ-038 Mid-word reset: rst low after 5 beats -> all outputs 0; the following 8 beats produce the correct word.
